// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester (IF, MEM) and RAM bus bundle for mem_ctrl.
//   slave  - the controller side (mem_ctrl)
//   master - the environment side (requesters + RAM)
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    // instruction fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;
    // data access requester
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    // byte-wide RAM port
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    // I/O write buffer back-pressure
    logic              io_full;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_data,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        output mem_done, mem_rdata,
        output ram_a, ram_wr, ram_dout,
        input  ram_din, io_full
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_data,
        output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        input  mem_done, mem_rdata,
        input  ram_a, ram_wr, ram_dout,
        output ram_din, io_full
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide RAM arbiter between instruction fetch and
// data access. Serialises 1/2/4-byte transactions into byte cycles, assembles
// read data little-endian and pulses a per-requester done.
// Optional feature macro: MEM_CTRL_IO_STALL_EN (writes at/above IO_BASE stall
// on io_full).
module mem_ctrl #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            r_state,     w_state_nx;
    logic [2:0]        r_cnt,       w_cnt_nx;
    logic [2:0]        r_len,       w_len_nx;
    logic [ADDR_W-1:0] r_addr,      w_addr_nx;
    logic [31:0]       r_wdata,     w_wdata_nx;
    logic [31:0]       r_buf,       w_buf_nx;
    logic [ADDR_W-1:0] r_ram_a,     w_ram_a_nx;
    logic              r_ram_wr,    w_ram_wr_nx;
    logic [7:0]        r_ram_dout,  w_ram_dout_nx;
    logic              r_if_done,   w_if_done_nx;
    logic [31:0]       r_if_data,   w_if_data_nx;
    logic              r_mem_done,  w_mem_done_nx;
    logic [31:0]       r_mem_rdata, w_mem_rdata_nx;
    logic [2:0]        w_mem_n;
    logic [2:0]        w_cnt_inc;
    logic              w_stall;

    // byte count from mem_len (encoding 2 is treated as a full word)
    assign w_mem_n   = (bus.mem_len == 2'd0) ? 3'd1 :
                       (bus.mem_len == 2'd1) ? 3'd2 : 3'd4;
    assign w_cnt_inc = r_cnt + 3'd1;

`ifdef MEM_CTRL_IO_STALL_EN
    logic r_io, w_io_nx;
    assign w_stall = r_io && bus.io_full;

    // I/O-region flag of the granted write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_io <= 1'b0;
        else      r_io <= w_io_nx;
    end

    // flag is only recomputed at a MEM grant
    always_comb begin
        w_io_nx = r_io;
        if (r_state == IDLE && bus.mem_req) w_io_nx = (bus.mem_addr >= IO_BASE);
    end
`else
    logic w_unused;
    assign w_stall  = 1'b0;
    assign w_unused = &{1'b0, bus.io_full, IO_BASE};
`endif

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_ram_a     <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= '0;
            r_if_done   <= 1'b0;
            r_if_data   <= '0;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_len       <= w_len_nx;
            r_addr      <= w_addr_nx;
            r_wdata     <= w_wdata_nx;
            r_buf       <= w_buf_nx;
            r_ram_a     <= w_ram_a_nx;
            r_ram_wr    <= w_ram_wr_nx;
            r_ram_dout  <= w_ram_dout_nx;
            r_if_done   <= w_if_done_nx;
            r_if_data   <= w_if_data_nx;
            r_mem_done  <= w_mem_done_nx;
            r_mem_rdata <= w_mem_rdata_nx;
        end
    end

    // arbitration, byte sequencing and read-data assembly
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_len_nx       = r_len;
        w_addr_nx      = r_addr;
        w_wdata_nx     = r_wdata;
        w_buf_nx       = r_buf;
        w_ram_a_nx     = r_ram_a;
        w_ram_wr_nx    = 1'b0;
        w_ram_dout_nx  = r_ram_dout;
        w_if_done_nx   = 1'b0;
        w_if_data_nx   = r_if_data;
        w_mem_done_nx  = 1'b0;
        w_mem_rdata_nx = r_mem_rdata;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    w_addr_nx  = bus.mem_addr;
                    w_len_nx   = w_mem_n;
                    w_wdata_nx = bus.mem_wdata;
                    w_cnt_nx   = '0;
                    w_buf_nx   = '0;
                    if (bus.mem_we) begin
                        w_state_nx = MEM_WR;
                    end else begin
                        w_state_nx = MEM_RD;
                        w_ram_a_nx = bus.mem_addr;
                    end
                end else if (bus.if_req && !bus.if_flush) begin
                    w_addr_nx  = bus.if_addr;
                    w_len_nx   = 3'd4;
                    w_cnt_nx   = '0;
                    w_buf_nx   = '0;
                    w_ram_a_nx = bus.if_addr;
                    w_state_nx = IF_RD;
                end
            end
            // Reads: the first address goes out at the grant edge, so each
            // edge here issues byte cnt+1 and captures byte cnt-1 (one-cycle
            // RAM latency); the edge with cnt == len captures the last byte.
            IF_RD, MEM_RD: begin
                if (r_state == IF_RD && bus.if_flush) begin
                    w_state_nx = IDLE;
                end else begin
                    if (w_cnt_inc < r_len)
                        w_ram_a_nx = r_addr + ADDR_W'(w_cnt_inc);
                    if (r_cnt != 3'd0)
                        w_buf_nx[{r_cnt - 3'd1, 3'b000} +: 8] = bus.ram_din;
                    if (r_cnt == r_len) begin
                        w_state_nx = IDLE;
                        if (r_state == IF_RD) begin
                            w_if_done_nx = 1'b1;
                            w_if_data_nx = w_buf_nx;
                        end else begin
                            w_mem_done_nx  = 1'b1;
                            w_mem_rdata_nx = w_buf_nx;
                        end
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            MEM_WR: begin
                if (r_cnt == r_len) begin
                    w_state_nx    = IDLE;
                    w_mem_done_nx = 1'b1;
                end else if (!w_stall) begin
                    w_ram_a_nx    = r_addr + ADDR_W'(r_cnt);
                    w_ram_wr_nx   = 1'b1;
                    w_ram_dout_nx = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                    w_cnt_nx      = w_cnt_inc;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.ram_a     = r_ram_a;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.if_done   = r_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a byte-level
// RAM model and a transaction-level reference memory image.
module tb_mem_ctrl;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_ctrl #(.ADDR_W(ADDR_W), .IO_BASE(32'h0003_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memory contents ----------------
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h00;
            32'h102: return 8'h00;
            32'h103: return 8'h93;
            32'h020: return 8'hAB;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    logic [7:0] ram_img [logic [31:0]];
    logic [7:0] ref_img [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_img.exists(a)) return ref_img[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
        return w;
    endfunction

    // synchronous RAM: data for the address seen at an edge appears after it
    always @(posedge clk) begin
        if (ram_img.exists(bus.ram_a)) bus.ram_din <= ram_img[bus.ram_a];
        else                           bus.ram_din <= init_byte(bus.ram_a);
        if (bus.ram_wr === 1'b1) ram_img[bus.ram_a] = bus.ram_dout;
    end

    // write beat log
    logic [39:0] wr_log[$];
    always @(negedge clk) if (bus.ram_wr === 1'b1) wr_log.push_back({bus.ram_a, bus.ram_dout});

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // waits (bounded) for the chosen done pulse; returns edges since call
    task automatic wait_done(input bit is_if, output int edges);
        bit got;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            got = is_if ? bus.if_done : bus.mem_done;
        end
    endtask

    // one complete transaction, entered and left at a falling edge
    task automatic run_txn(input string tag, input bit is_if, input bit we,
                           input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata);
        int          n;
        int          edges;
        logic [31:0] exp_d;
        n     = is_if ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        exp_d = ref_word(addr, n);
        wr_log.delete();
        if (is_if) begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.mem_addr  = addr;
            bus.mem_we    = we;
            bus.mem_len   = len;
            bus.mem_wdata = wdata;
            bus.mem_req   = 1'b1;
        end
        wait_done(is_if, edges);
        check({tag, "_lat"}, 64'(edges), 64'(n + 2));
        if (is_if)    check({tag, "_ifdata"}, 64'(bus.if_data), 64'(exp_d));
        else if (!we) check({tag, "_rdata"}, 64'(bus.mem_rdata), 64'(exp_d));
        else begin
            check({tag, "_nbeats"}, 64'(wr_log.size()), 64'(n));
            for (int k = 0; k < n && k < wr_log.size(); k++)
                check({tag, "_beat"}, 64'(wr_log[k]), 64'({addr + 32'(k), wdata[8*k +: 8]}));
            for (int k = 0; k < n; k++) ref_img[addr + 32'(k)] = wdata[8*k +: 8];
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse1"}, 64'(is_if ? bus.if_done : bus.mem_done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        logic [31:0] a;
        rst           = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_len   = '0;
        bus.mem_wdata = '0;
        bus.io_full   = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_outs", 64'({bus.if_done, bus.mem_done, bus.ram_wr, bus.ram_dout}), 64'd0);
        check("rst_addr", 64'(bus.ram_a), 64'd0);
        check("rst_data", {bus.if_data, bus.mem_rdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // IF fetch of a known instruction word
        run_txn("if_0x100", 1'b1, 1'b0, 32'h100, 2'd0, '0);
        check("if_word", 64'(bus.if_data), 64'h9300_0013);

        // simultaneous requests: MEM wins, IF follows
        bus.mem_addr = 32'h20; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_req = 1'b1;
        bus.if_addr  = 32'h100; bus.if_req = 1'b1;
        wait_done(1'b0, edges);
        check("arb_mem_lat", 64'(edges), 64'd3);
        check("arb_mem_rdata", 64'(bus.mem_rdata), 64'h0000_00AB);
        check("arb_if_waits", 64'(bus.if_done), 64'd0);
        bus.mem_req = 1'b0;
        wait_done(1'b1, edges);
        check("arb_if_lat", 64'(edges), 64'd6);
        check("arb_if_data", 64'(bus.if_data), 64'h9300_0013);
        bus.if_req = 1'b0;
        @(posedge clk); @(negedge clk);

        // two-byte write
        run_txn("wr2_0x40", 1'b0, 1'b1, 32'h40, 2'd1, 32'h0000_1234);
        run_txn("rd2_0x40", 1'b0, 1'b0, 32'h40, 2'd1, '0);
        check("rd2_val", 64'(bus.mem_rdata), 64'h0000_1234);

        // flush mid-fetch, then refetch from a new address
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        bus.if_flush = 1'b1; bus.if_addr = 32'h200;
        @(posedge clk); @(negedge clk);
        check("flush_nodone", 64'(bus.if_done), 64'd0);
        bus.if_flush = 1'b0;
        wait_done(1'b1, edges);
        check("flush_lat", 64'(edges), 64'd6);
        check("flush_data", 64'(bus.if_data), 64'(ref_word(32'h200, 4)));
        bus.if_req = 1'b0;
        @(posedge clk); @(negedge clk);

        // reset in the middle of a write
        bus.mem_addr = 32'h7000; bus.mem_we = 1'b1; bus.mem_len = 2'd1;
        bus.mem_wdata = 32'hBEEF; bus.mem_req = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("rstw_inprog", 64'(bus.ram_wr), 64'd1);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_wr", 64'(bus.ram_wr), 64'd0);
        check("rstw_done", 64'(bus.mem_done), 64'd0);
        check("rstw_addr", 64'(bus.ram_a), 64'd0);
        bus.mem_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("rstw_idle", 64'({bus.mem_done, bus.ram_wr}), 64'd0);
        end
        run_txn("post_rst_rd", 1'b0, 1'b0, 32'h100, 2'd3, '0);

        // address wrap-around
        run_txn("wrap_wr", 1'b0, 1'b1, 32'hFFFF_FFFE, 2'd3, 32'hCAFE_F00D);
        run_txn("wrap_if", 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd0, '0);
        run_txn("wrap_rd", 1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, '0);

        // RAM-region write never stalls, even with io_full high
        bus.io_full = 1'b1;
        run_txn("ram_wr_iofull", 1'b0, 1'b1, 32'h50, 2'd0, 32'h77);
        bus.io_full = 1'b0;

        // I/O-region write with io_full high for three cycles after grant
        wr_log.delete();
        bus.mem_addr = 32'h0003_0004; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
        bus.mem_wdata = 32'h5C; bus.mem_req = 1'b1;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) bus.io_full = 1'b1;
            if (edges == 4) bus.io_full = 1'b0;
            if (bus.mem_done) break;
        end
`ifdef MEM_CTRL_IO_STALL_EN
        check("io_lat", 64'(edges), 64'd6);
`else
        check("io_lat", 64'(edges), 64'd3);
`endif
        check("io_nbeats", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) check("io_beat", 64'(wr_log[0]), 64'({32'h0003_0004, 8'h5C}));
        bus.io_full = 1'b0;
        bus.mem_req = 1'b0;
        @(posedge clk); @(negedge clk);

        // randomized traffic against the reference image
        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            kind = $urandom_range(0, 2);
            a = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'h0) + 32'($urandom_range(0, 15));
            case (kind)
                0:       run_txn("rnd_if", 1'b1, 1'b0, a, 2'd0, '0);
                1:       run_txn("rnd_rd", 1'b0, 1'b0, a, 2'($urandom_range(0, 3)), '0);
                default: run_txn("rnd_wr", 1'b0, 1'b1, a, 2'($urandom_range(0, 3)), $urandom);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
